// File: rtl/demux1_4_pkg.sv
// Constants shared by the mux4_1 / demux1_4 pair: channel count, select width, counter width.
// Also holds the select-to-one-hot helper used for slot write enables.
package demux1_4_pkg;

  localparam int NumCh       = 4;
  localparam int SelWidth    = 2;
  localparam int DefCntWidth = 16;

  typedef logic [SelWidth-1:0] sel_t;

  function automatic logic [NumCh-1:0] sel_onehot(input sel_t sel);
    sel_onehot = {{(NumCh-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/demux1_4_slot.sv
// One-entry output slot with valid/ready handshake and delivered-word counter; 1 cycle write-to-valid.
// Accepts a new word when empty or when draining the same cycle (full throughput, no bubble).
module demux_slot #(
  parameter int Width    = 8,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                wr_i,
  input  logic [Width-1:0]    wr_dat_i,
  input  logic                rdy_i,
  output logic [Width-1:0]    dat_o,
  output logic                vld_o,
  output logic [CntWidth-1:0] cnt_o,
  output logic                acc_o
);

  logic drain;

  assign drain = vld_o & rdy_i;
  assign acc_o = ~vld_o | rdy_i;

  // Data is only overwritten on a write, so it holds while stalled and after draining.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o <= '0;
      vld_o <= 1'b0;
    end else if (wr_i) begin
      dat_o <= wr_dat_i;
      vld_o <= 1'b1;
    end else if (drain) begin
      vld_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (drain) begin
      cnt_o <= cnt_o + CntWidth'(1);
    end
  end

endmodule

// File: rtl/demux1_4.sv
// 1-to-4 demultiplexer with a one-entry slot per channel; input to output latency 1 cycle.
// ready_o reflects only the selected slot, so a stalled channel never blocks the others.
module demux1_4
  import demux1_4_pkg::*;
#(
  parameter int Width    = 8,
  parameter int CntWidth = DefCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [Width-1:0]    in1_i,
  input  logic [1:0]          sel_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [Width-1:0]    ou1_o,
  output logic [Width-1:0]    ou2_o,
  output logic [Width-1:0]    ou3_o,
  output logic [Width-1:0]    ou4_o,
  output logic                valid1_o,
  output logic                valid2_o,
  output logic                valid3_o,
  output logic                valid4_o,
  input  logic                ready1_i,
  input  logic                ready2_i,
  input  logic                ready3_i,
  input  logic                ready4_i,
  output logic [CntWidth-1:0] cnt1_o,
  output logic [CntWidth-1:0] cnt2_o,
  output logic [CntWidth-1:0] cnt3_o,
  output logic [CntWidth-1:0] cnt4_o
);

  logic [NumCh-1:0]    slot_wr;
  logic [NumCh-1:0]    slot_acc;
  logic [NumCh-1:0]    slot_rdy;
  logic [NumCh-1:0]    slot_vld;
  logic [Width-1:0]    slot_dat [NumCh];
  logic [CntWidth-1:0] slot_cnt [NumCh];

  assign slot_rdy = {ready4_i, ready3_i, ready2_i, ready1_i};
  assign ready_o  = slot_acc[sel_i];

  // Only the selected slot is ever written, and only on an accepted transfer.
  always_comb begin
    slot_wr = '0;
    if (valid_i && ready_o) begin
      slot_wr = sel_onehot(sel_i);
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_slot
    demux_slot #(
      .Width    (Width),
      .CntWidth (CntWidth)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_i),
      .wr_i     (slot_wr[g]),
      .wr_dat_i (in1_i),
      .rdy_i    (slot_rdy[g]),
      .dat_o    (slot_dat[g]),
      .vld_o    (slot_vld[g]),
      .cnt_o    (slot_cnt[g]),
      .acc_o    (slot_acc[g])
    );
  end

  assign ou1_o    = slot_dat[0];
  assign ou2_o    = slot_dat[1];
  assign ou3_o    = slot_dat[2];
  assign ou4_o    = slot_dat[3];
  assign valid1_o = slot_vld[0];
  assign valid2_o = slot_vld[1];
  assign valid3_o = slot_vld[2];
  assign valid4_o = slot_vld[3];
  assign cnt1_o   = slot_cnt[0];
  assign cnt2_o   = slot_cnt[1];
  assign cnt3_o   = slot_cnt[2];
  assign cnt4_o   = slot_cnt[3];

endmodule

// File: tb/tb_demux1_4.sv
// Bench for demux1_4: directed vectors feed a per-channel scoreboard checked by a negedge monitor.
module tb_demux1_4;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [7:0]  din;
  logic [1:0]  sel;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  rdy;
  logic [3:0]  vld;
  logic [7:0]  ou  [4];
  logic [15:0] cnt [4];

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  q [4][$];
  logic [7:0]  exp_dat [4];
  logic [15:0] exp_cnt [4];

  demux1_4 #(.Width(8), .CntWidth(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (clr),
    .in1_i    (din),
    .sel_i    (sel),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ou1_o    (ou[0]),
    .ou2_o    (ou[1]),
    .ou3_o    (ou[2]),
    .ou4_o    (ou[3]),
    .valid1_o (vld[0]),
    .valid2_o (vld[1]),
    .valid3_o (vld[2]),
    .valid4_o (vld[3]),
    .ready1_i (rdy[0]),
    .ready2_i (rdy[1]),
    .ready3_i (rdy[2]),
    .ready4_i (rdy[3]),
    .cnt1_o   (cnt[0]),
    .cnt2_o   (cnt[1]),
    .cnt3_o   (cnt[2]),
    .cnt4_o   (cnt[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs settle at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    logic       exp_rdy;
    logic [7:0] front;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        exp_dat[n] = 8'h00;
        exp_cnt[n] = 16'h0000;
      end
    end else begin
      exp_rdy = (q[sel].size() == 0) || rdy[sel];
      chk("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("valid%0d", n + 1), {31'd0, vld[n]}, {31'd0, q[n].size() != 0});
        chk($sformatf("ou%0d", n + 1), {24'd0, ou[n]}, {24'd0, exp_dat[n]});
        chk($sformatf("cnt%0d", n + 1), {16'd0, cnt[n]}, {16'd0, exp_cnt[n]});
        if (q[n].size() != 0 && rdy[n]) begin
          front = q[n].pop_front();
          chk($sformatf("deliver%0d", n + 1), {24'd0, ou[n]}, {24'd0, front});
          exp_cnt[n] = exp_cnt[n] + 16'd1;
        end
        if (clr) exp_cnt[n] = 16'h0000;
      end
      if (valid_i && exp_rdy) begin
        q[sel].push_back(din);
        exp_dat[sel] = din;
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; din = 8'h00; sel = 2'd0; valid_i = 1'b0; rdy = 4'b0000;
    #2;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {28'd0, vld}, 32'd0);
    chk("rst_cnt", {cnt[0], cnt[3]}, 32'd0);
    step(); step();
    rst = 1'b0;

    // Single word to channel 3, drained the following cycle.
    valid_i = 1'b1; sel = 2'd2; din = 8'hA5; rdy = 4'b0100;
    step();
    valid_i = 1'b0;
    chk("c31_ou3", {24'd0, ou[2]}, 32'hA5);
    chk("c31_valid", {28'd0, vld}, 32'h4);
    chk("c31_others", {8'd0, ou[0], ou[1], ou[3]}, 32'd0);
    step();
    chk("c31_cnt3", {16'd0, cnt[2]}, 32'd1);
    chk("c31_valid3", {31'd0, vld[2]}, 32'd0);

    // Backpressure on channel 2, then release with no bubble.
    rdy = 4'b0000; valid_i = 1'b1; sel = 2'd1; din = 8'h11;
    #1 chk("c32_rdy_first", {31'd0, ready_o}, 32'd1);
    step();
    din = 8'h22;
    #1 chk("c32_rdy_block", {31'd0, ready_o}, 32'd0);
    step();
    chk("c32_rdy_stall", {31'd0, ready_o}, 32'd0);
    chk("c32_hold", {24'd0, ou[1]}, 32'h11);
    rdy[1] = 1'b1;
    #1 chk("c32_rdy_release", {31'd0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    chk("c32_nobubble_v", {31'd0, vld[1]}, 32'd1);
    chk("c32_nobubble_d", {24'd0, ou[1]}, 32'h22);
    step();
    chk("c32_cnt2", {16'd0, cnt[1]}, 32'd2);
    chk("c32_empty_keep", {24'd0, ou[1]}, 32'h22);

    // Stalled channel 1 must not block channel 4.
    rdy = 4'b0000; valid_i = 1'b1; sel = 2'd0; din = 8'h5A;
    step();
    sel = 2'd3; din = 8'h33;
    #1 chk("c33_ready", {31'd0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    chk("c33_ou4", {24'd0, ou[3]}, 32'h33);
    chk("c33_ou1", {24'd0, ou[0]}, 32'h5A);
    rdy = 4'b1111;
    step(); step();

    // Counter wrap on channel 4 and clear-over-increment.
    clr = 1'b1; step(); clr = 1'b0;
    valid_i = 1'b1; sel = 2'd3;
    for (int i = 0; i < 65535; i++) begin
      din = 8'(i);
      step();
    end
    valid_i = 1'b0;
    step();
    chk("c34_full", {16'd0, cnt[3]}, 32'hFFFF);
    valid_i = 1'b1; din = 8'hC3; step(); valid_i = 1'b0; step();
    chk("c34_wrap", {16'd0, cnt[3]}, 32'h0);
    valid_i = 1'b1; din = 8'h3C; step(); valid_i = 1'b0; step();
    chk("c34_one", {16'd0, cnt[3]}, 32'h1);
    valid_i = 1'b1; din = 8'h96; step(); valid_i = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    chk("c34_clr_win", {16'd0, cnt[3]}, 32'h0);
    chk("c34_drained", {31'd0, vld[3]}, 32'd0);

    // Asynchronous reset with all slots full.
    rdy = 4'b0000; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); din = 8'(8'h40 + i);
      step();
    end
    valid_i = 1'b0;
    chk("c35_full", {28'd0, vld}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("c35_valid", {28'd0, vld}, 32'd0);
    chk("c35_cnt", {cnt[0] | cnt[1], cnt[2] | cnt[3]}, 32'd0);
    chk("c35_ou", {ou[0], ou[1], ou[2], ou[3]}, 32'd0);
    chk("c35_ready", {31'd0, ready_o}, 32'd1);
    step();
    rst = 1'b0;
    valid_i = 1'b1; sel = 2'd0; din = 8'h77;
    step();
    valid_i = 1'b0;
    chk("c28_first_v", {31'd0, vld[0]}, 32'd1);
    chk("c28_first_d", {24'd0, ou[0]}, 32'h77);
    rdy = 4'b1111;
    step();

    // Randomised traffic; the monitor checks order, data, valids and counters.
    for (int i = 0; i < 10000; i++) begin
      valid_i = 1'($urandom);
      sel     = 2'($urandom);
      din     = 8'($urandom);
      rdy     = 4'($urandom);
      clr     = ($urandom_range(0, 199) == 0);
      step();
    end
    valid_i = 1'b0; clr = 1'b0; rdy = 4'b1111;
    step(); step();
    chk("final_empty", {28'd0, vld}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/demux1_4.md
DEMUX1_4 -- requirements
Module: demux1_4

Interface
REQ-001 The module SHALL have parameter Width, default 8, giving the data width of the input and each output.
REQ-002 The module SHALL have parameter CntWidth, default 16, giving the width of each per-channel transfer counter.
REQ-003 The module SHALL have clk_i, input, 1 bit, as its single clock; all state changes on its rising edge.
REQ-004 The module SHALL have rst_i, input, 1 bit, reset that is asynchronous and active-high.
REQ-005 The module SHALL have in1_i, input, Width bits, the input data word.
REQ-006 The module SHALL have sel_i, input, 2 bits, the destination channel: 0->ch1, 1->ch2, 2->ch3, 3->ch4.
REQ-007 The module SHALL have valid_i, input, 1 bit, meaning in1_i/sel_i carry a word to route.
REQ-008 The module SHALL have ready_o, output, 1 bit, meaning the word is accepted this cycle.
REQ-009 The module SHALL have ou1_o..ou4_o, outputs, Width bits each, the per-channel output data.
REQ-010 The module SHALL have valid1_o..valid4_o, outputs, 1 bit each, meaning the matching ouN_o holds a word.
REQ-011 The module SHALL have ready1_i..ready4_i, inputs, 1 bit each, meaning the channel consumer takes the word.
REQ-012 The module SHALL have cnt1_o..cnt4_o, outputs, CntWidth bits each, the delivered-word count per channel.
REQ-013 The module SHALL have clr_i, input, 1 bit, a synchronous clear of all four counters.

Function
REQ-014 Each channel SHALL hold a one-entry slot (data + valid); ouN_o/validN_o are driven directly from slot N registers.
REQ-015 ready_o SHALL be combinational: high when the slot selected by sel_i is empty, or is full and its readyN_i is high.
REQ-016 An input transfer SHALL occur on a cycle with valid_i=1 and ready_o=1; the word SHALL appear on ou[sel_i]_o with valid high on the next cycle (latency 1).
REQ-017 An output transfer on channel N SHALL occur on a cycle with validN_o=1 and readyN_i=1; the slot empties next cycle unless refilled.
REQ-018 Simultaneous input transfer to channel N and output transfer from channel N SHALL load the new word with validN_o staying high (no bubble).
REQ-019 At most one slot SHALL be written per cycle; all four slots SHALL drain independently and concurrently.
REQ-020 While validN_o=1 and readyN_i=0, ouN_o SHALL remain stable.
REQ-021 When a slot empties, ouN_o SHALL retain its last value; only validN_o falls.
REQ-022 sel_i and in1_i SHALL be ignored when valid_i=0; ready_o still follows REQ-015.
REQ-023 cntN_o SHALL increment by 1 on each channel-N output transfer, wrapping from 2^CntWidth-1 to 0.
REQ-024 clr_i=1 SHALL set all counters to 0 next cycle; clear SHALL win over a same-cycle increment.
REQ-025 Input data SHALL be delivered in acceptance order per channel; no word is ever dropped or duplicated.

Reset
REQ-026 rst_i=1 SHALL immediately force validN_o=0, ouN_o=0, cntN_o=0 for all channels.
REQ-027 Reset mid-operation SHALL discard all held words; ready_o is high after reset (all slots empty).
REQ-028 The first transfer SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-029 Channel count (4), select width (2) and default CntWidth (16) SHALL live in the shared mux/demux constants package used with mux4_1.
REQ-030 One sub-module, demux_slot (one-entry register, its handshake and its counter), SHALL be instantiated four times; demux1_4 holds only select decode and ready_o.

Verification
REQ-031 Reset, then valid_i=1, sel_i=2, in1_i=0xA5, ready3_i=1 -> next cycle ou3_o=0xA5, valid3_o=1, others 0; cycle after, cnt3_o=1, valid3_o=0.
REQ-032 ready2_i=0, two words 0x11, 0x22 to sel_i=1 -> 0x11 accepted, ready_o=0 for 0x22 until ready2_i=1; then 0x22 follows with no bubble.
REQ-033 Slot 1 stalled (ready1_i=0) full, word 0x33 to sel_i=3 -> ready_o=1, accepted, ou4_o=0x33 next cycle; ou1_o unchanged.
REQ-034 Preload cnt4_o=0xFFFF via 65535 transfers, one more -> cnt4_o=0x0000; clr_i coinciding with a drain -> counter 0.
REQ-035 Assert rst_i asynchronously with all four slots full -> all valids and counters 0 before next edge; ready_o=1.
REQ-036 Random valid_i/sel_i/readyN_i for 10000 cycles -> per-channel scoreboard matches order and count, cntN_o equals delivered words.
